// File: rtl/instruction_loader.sv
// Streams UART bytes into 32-bit big-endian instruction words and writes them to instruction memory.
// A load starts on i_start and stops on the HALT word or when the last word slot has been written.
module instruction_loader #(
  parameter int          INST_MEM_ADDR_WIDTH = 9,
  parameter logic [31:0] HALT_INSTRUCTION    = 32'hFFFFFFFF
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [7:0]                     i_rx_data,
  input  logic                           i_rx_valid,
  output logic                           o_write_instruction_flag,
  output logic [31:0]                    o_instruction_to_write,
  output logic [INST_MEM_ADDR_WIDTH-1:0] o_address_to_write_inst,
  output logic                           o_loading,
  output logic                           o_done,
  output logic                           o_overflow,
  output logic [INST_MEM_ADDR_WIDTH-2:0] o_word_count
);

  localparam int AW        = INST_MEM_ADDR_WIDTH;
  localparam int WC_W      = AW - 1;
  localparam int CNT_MAX_I = (1 << (AW - 2)) - 1;

  localparam logic [AW-1:0]   LAST_ADDR = {{(AW-2){1'b1}}, 2'b00};
  localparam logic [WC_W-1:0] CNT_MAX   = WC_W'(CNT_MAX_I);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     shift_q, shift_d;
  logic [31:0]     word_q, word_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [WC_W-1:0] count_q, count_d;
  logic            wr_q, wr_d;
  logic            loading_q, loading_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_d       = 1'b0;
    done_d     = done_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d    = ST_RECEIVE;
          addr_d     = '0;
          count_d    = '0;
          byte_cnt_d = '0;
          done_d     = 1'b0;
          ovf_d      = 1'b0;
        end
      end

      ST_RECEIVE: begin
        if (i_rx_valid) begin
          shift_d    = {shift_q[15:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            word_d  = {shift_q, i_rx_data};
            wr_d    = 1'b1;
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // A byte landing here is the first byte of the next word; it must not be dropped.
        if (i_rx_valid) begin
          shift_d    = {shift_q[15:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
        if (count_q != CNT_MAX) begin
          count_d = count_q + WC_W'(1);
        end
        if ((word_q == HALT_INSTRUCTION) || (addr_q == LAST_ADDR)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          ovf_d   = (word_q != HALT_INSTRUCTION);
        end else begin
          state_d = ST_RECEIVE;
          addr_d  = addr_q + AW'(4);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    loading_d = (state_d == ST_RECEIVE) || (state_d == ST_WRITE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      wr_q       <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      loading_q  <= loading_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_write_instruction_flag = wr_q;
  assign o_instruction_to_write   = word_q;
  assign o_address_to_write_inst  = addr_q;
  assign o_loading                = loading_q;
  assign o_done                   = done_q;
  assign o_overflow               = ovf_q;
  assign o_word_count             = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: reset, single word, HALT-terminated program,
// back-to-back bytes, memory-full overflow and reset in the middle of a word.
module tb_instruction_loader;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          wr_flag;
  logic [31:0]   wr_word;
  logic [AW-1:0] wr_addr;
  logic          loading;
  logic          done;
  logic          ovf;
  logic [AW-2:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] q_addr[$];
  logic [31:0]   q_word[$];

  instruction_loader #(
    .INST_MEM_ADDR_WIDTH(AW),
    .HALT_INSTRUCTION   (32'hFFFFFFFF)
  ) dut (
    .i_clk                   (clk),
    .i_reset                 (rst_n),
    .i_start                 (start),
    .i_rx_data               (rx_data),
    .i_rx_valid              (rx_valid),
    .o_write_instruction_flag(wr_flag),
    .o_instruction_to_write  (wr_word),
    .o_address_to_write_inst (wr_addr),
    .o_loading               (loading),
    .o_done                  (done),
    .o_overflow              (ovf),
    .o_word_count            (word_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Record every write seen by memory; each one must be word-aligned.
  always @(negedge clk) begin
    if (wr_flag === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_word.push_back(wr_word);
      check_eq("addr_align", {30'd0, wr_addr[1:0]}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  int base;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // 1: reset held for three cycles, then bytes in IDLE are ignored
    repeat (3) tick();
    check_eq("rst_flag",    {31'd0, wr_flag}, 32'd0);
    check_eq("rst_word",    wr_word, 32'd0);
    check_eq("rst_addr",    {23'd0, wr_addr}, 32'd0);
    check_eq("rst_loading", {31'd0, loading}, 32'd0);
    check_eq("rst_done",    {31'd0, done}, 32'd0);
    check_eq("rst_ovf",     {31'd0, ovf}, 32'd0);
    check_eq("rst_count",   {24'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    send_word(32'h12345678);
    tick();
    check_eq("idle_no_write", q_addr.size(), 32'd0);
    check_eq("idle_loading",  {31'd0, loading}, 32'd0);

    // 2: single word, write pulse one cycle after the fourth byte
    pulse_start();
    check_eq("t2_loading", {31'd0, loading}, 32'd1);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    check_eq("t2_no_early_write", {31'd0, wr_flag}, 32'd0);
    send_byte(8'h05);
    check_eq("t2_flag", {31'd0, wr_flag}, 32'd1);
    check_eq("t2_word", wr_word, 32'h20080005);
    check_eq("t2_addr", {23'd0, wr_addr}, 32'd0);
    check_eq("t2_loading_w", {31'd0, loading}, 32'd1);
    tick();
    check_eq("t2_flag_one_cycle", {31'd0, wr_flag}, 32'd0);

    // 3: two more words and HALT finish the program at address 12
    send_word(32'h8C010004);
    tick();
    send_word(32'hAC020008);
    tick();
    send_word(32'hFFFFFFFF);
    tick();
    check_eq("t3_writes", q_addr.size(), 32'd4);
    check_eq("t3_addr1", {23'd0, q_addr[1]}, 32'd4);
    check_eq("t3_addr2", {23'd0, q_addr[2]}, 32'd8);
    check_eq("t3_addr3", {23'd0, q_addr[3]}, 32'd12);
    check_eq("t3_word1", q_word[1], 32'h8C010004);
    check_eq("t3_halt",  q_word[3], 32'hFFFFFFFF);
    check_eq("t3_done",    {31'd0, done}, 32'd1);
    check_eq("t3_ovf",     {31'd0, ovf}, 32'd0);
    check_eq("t3_count",   {24'd0, word_count}, 32'd4);
    check_eq("t3_loading", {31'd0, loading}, 32'd0);

    // 4: restart from DONE, then bytes every cycle across two words
    pulse_start();
    check_eq("t4_done_clr",  {31'd0, done}, 32'd0);
    check_eq("t4_count_clr", {24'd0, word_count}, 32'd0);
    base = q_addr.size();
    send_word(32'h11223344);
    send_word(32'h55667788);
    tick();
    check_eq("t4_writes", q_addr.size() - base, 32'd2);
    check_eq("t4_word0",  q_word[base],     32'h11223344);
    check_eq("t4_word1",  q_word[base + 1], 32'h55667788);
    check_eq("t4_addr0",  {23'd0, q_addr[base]},     32'd0);
    check_eq("t4_addr1",  {23'd0, q_addr[base + 1]}, 32'd4);
    send_word(32'hFFFFFFFF);
    tick();
    check_eq("t4_done", {31'd0, done}, 32'd1);

    // 5: 128 non-HALT words fill memory
    pulse_start();
    base = q_addr.size();
    for (int i = 0; i < 128; i++) begin
      send_word(32'h01000000 + i);
    end
    tick();
    check_eq("t5_writes",    q_addr.size() - base, 32'd128);
    check_eq("t5_last_addr", {23'd0, q_addr[q_addr.size() - 1]}, 32'd508);
    check_eq("t5_last_word", q_word[q_word.size() - 1], 32'h0100007F);
    check_eq("t5_done",      {31'd0, done}, 32'd1);
    check_eq("t5_ovf",       {31'd0, ovf}, 32'd1);
    check_eq("t5_count",     {24'd0, word_count}, 32'd127);
    check_eq("t5_loading",   {31'd0, loading}, 32'd0);
    send_word(32'hCAFEF00D);
    tick();
    check_eq("t5_done_ignores_bytes", q_addr.size() - base, 32'd128);

    // 6: reset after two bytes, then a clean word at address 0
    pulse_start();
    check_eq("t6_ovf_clr", {31'd0, ovf}, 32'd0);
    base = q_addr.size();
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t6_rst_loading", {31'd0, loading}, 32'd0);
    check_eq("t6_rst_addr",    {23'd0, wr_addr}, 32'd0);
    tick();
    pulse_start();
    send_word(32'hDEADBEEF);
    tick();
    check_eq("t6_writes", q_addr.size() - base, 32'd1);
    check_eq("t6_word",   q_word[q_word.size() - 1], 32'hDEADBEEF);
    check_eq("t6_addr",   {23'd0, q_addr[q_addr.size() - 1]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
